// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, CTRL bit positions and default window base for mmio_port_unit
package mmio_pkg;
   localparam logic [31:0] DEFAULT_BASE = 32'h1001_0100;
   localparam logic [4:0] OFS_PORT_OUT = 5'h00;
   localparam logic [4:0] OFS_PORT_IN  = 5'h04;
   localparam logic [4:0] OFS_EDGE     = 5'h08;
   localparam logic [4:0] OFS_CTRL     = 5'h0C;
   localparam logic [4:0] OFS_CMP      = 5'h10;
   localparam logic [4:0] OFS_CNT      = 5'h14;
   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQEN  = 2;
   localparam int CTRL_STATUS = 3;
endpackage

// File: rtl/port_in_sync.sv
// port_in_sync: multi-flop synchroniser for PortIn plus a prev flop for rising-edge detection
module port_in_sync #(
   parameter int IN_WIDTH    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IN_WIDTH-1:0] port_in,
   output logic [IN_WIDTH-1:0] sync_value,
   output logic [IN_WIDTH-1:0] rise_pulse
);
   logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] chain;
   logic [IN_WIDTH-1:0]                  prev;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= '0;
         prev  <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], port_in};
         prev  <= chain[SYNC_STAGES-1];
      end
   end
   assign sync_value = chain[SYNC_STAGES-1];
   assign rise_pulse = sync_value & ~prev;
endmodule

// File: rtl/mmio_port_unit.sv
// mmio_port_unit: memory-mapped PortOut/PortIn/edge-flag/timer registers behind the MIPS datapath
module mmio_port_unit
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE,
   parameter int          IN_WIDTH    = 8,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                MemWrite,
   input  logic                MemRead,
   input  logic [31:0]         Address,
   input  logic [31:0]         WriteData,
   output logic [31:0]         ReadData,
   output logic                Hit,
   input  logic [IN_WIDTH-1:0] PortIn,
   output logic [31:0]         PortOut,
   output logic                TimerIRQ
);
   logic [IN_WIDTH-1:0] sync_value, rise_pulse, edge_q;
   logic [31:0]         cmp_q, cnt_q, ctrl_val, reg_val;
   logic                en_q, auto_q, irqen_q, status_q;
   logic [4:0]          ofs;
   logic                wr, wr_port, wr_edge, wr_ctrl, wr_cmp, wr_cnt, match;

   port_in_sync #(.IN_WIDTH(IN_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .port_in   (PortIn),
      .sync_value(sync_value),
      .rise_pulse(rise_pulse)
   );

   assign ofs = Address[4:0];
   // word-aligned offsets 0x00..0x14 are exactly the six mapped registers
   assign Hit = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00) && (ofs <= OFS_CNT);

   always_comb begin
      ctrl_val              = '0;
      ctrl_val[CTRL_EN]     = en_q;
      ctrl_val[CTRL_AUTO]   = auto_q;
      ctrl_val[CTRL_IRQEN]  = irqen_q;
      ctrl_val[CTRL_STATUS] = status_q;
      reg_val = ofs == OFS_PORT_OUT ? PortOut :
                ofs == OFS_PORT_IN  ? 32'(sync_value) :
                ofs == OFS_EDGE     ? 32'(edge_q) :
                ofs == OFS_CTRL     ? ctrl_val :
                ofs == OFS_CMP      ? cmp_q : cnt_q;
   end

   assign ReadData = (MemRead && Hit) ? reg_val : '0;
   assign wr       = MemWrite && Hit;
   assign wr_port  = wr && ofs == OFS_PORT_OUT;
   assign wr_edge  = wr && ofs == OFS_EDGE;
   assign wr_ctrl  = wr && ofs == OFS_CTRL;
   assign wr_cmp   = wr && ofs == OFS_CMP;
   assign wr_cnt   = wr && ofs == OFS_CNT;
   assign match    = en_q && cnt_q == cmp_q;
   assign TimerIRQ = status_q && irqen_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PortOut  <= '0;
         edge_q   <= '0;
         cmp_q    <= '0;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         auto_q   <= 1'b0;
         irqen_q  <= 1'b0;
         status_q <= 1'b0;
      end else begin
         if (wr_port) PortOut <= WriteData;
         if (wr_cmp) cmp_q <= WriteData;
         // a fresh rising edge beats a simultaneous W1C of the same bit
         edge_q   <= (edge_q & ~(wr_edge ? WriteData[IN_WIDTH-1:0] : '0)) | rise_pulse;
         cnt_q    <= wr_cnt ? WriteData : match ? '0 : en_q ? cnt_q + 32'd1 : cnt_q;
         en_q     <= wr_ctrl ? WriteData[CTRL_EN] : match ? auto_q : en_q;
         status_q <= match || (status_q && !(wr_ctrl && WriteData[CTRL_STATUS]));
         if (wr_ctrl) begin
            auto_q  <= WriteData[CTRL_AUTO];
            irqen_q <= WriteData[CTRL_IRQEN];
         end
      end
   end
endmodule

// File: tb/tb_mmio_port_unit.sv
// tb_mmio_port_unit: scoreboard-driven bench for mmio_port_unit
module tb_mmio_port_unit;
   localparam logic [31:0] BASE = 32'h1001_0100;
   logic        clk = 0, reset = 1, MemWrite = 0, MemRead = 0, Hit, TimerIRQ;
   logic [31:0] Address = 0, WriteData = 0, ReadData, PortOut;
   logic [7:0]  PortIn = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e, v;
   logic        h;
   int          n_run = 0, n_fail = 0;

   mmio_port_unit dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit),
      .PortIn(PortIn), .PortOut(PortOut), .TimerIRQ(TimerIRQ)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      MemWrite = 1; Address = a; WriteData = d;
      @(posedge clk);
      #1;
      MemWrite = 0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic hit);
      MemRead = 1; Address = a;
      #1;
      d = ReadData; hit = Hit;
      MemRead = 0;
   endtask

   task automatic test_reset;
      #3;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_run++;
      if (PortOut !== e) begin n_fail++; $display("FAIL reset_portout got %h exp %h", PortOut, e); end
      e = exp_q.pop_front(); n_run++;
      if (32'(TimerIRQ) !== e) begin n_fail++; $display("FAIL reset_irq got %h exp %h", TimerIRQ, e); end
      tick(2);
      @(negedge clk);
      reset = 0;
      tick(1);
   endtask

   task automatic test_port;
      wr(BASE, 32'hA5);
      exp_q.push_back(32'hA5);
      e = exp_q.pop_front(); n_run++;
      if (PortOut !== e) begin n_fail++; $display("FAIL port_out got %h exp %h", PortOut, e); end
      rd(BASE, v, h);
      exp_q.push_back(32'hA5);
      exp_q.push_back(32'h1);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL port_read got %h exp %h", v, e); end
      e = exp_q.pop_front(); n_run++;
      if (32'(h) !== e) begin n_fail++; $display("FAIL port_hit got %h exp %h", h, e); end
      MemWrite = 1; Address = BASE + 2; WriteData = 32'h55;
      #1;
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_run++;
      if (32'(Hit) !== e) begin n_fail++; $display("FAIL misalign_hit got %h exp %h", Hit, e); end
      @(posedge clk);
      #1;
      MemWrite = 0;
      exp_q.push_back(32'hA5);
      e = exp_q.pop_front(); n_run++;
      if (PortOut !== e) begin n_fail++; $display("FAIL misalign_nowrite got %h exp %h", PortOut, e); end
      rd(BASE + 2, v, h);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL misalign_read got %h exp %h", v, e); end
      MemRead = 1; MemWrite = 1; Address = BASE; WriteData = 32'h11;
      #1;
      v = ReadData;
      @(posedge clk);
      #1;
      MemRead = 0; MemWrite = 0;
      exp_q.push_back(32'hA5);
      exp_q.push_back(32'h11);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL rw_preread got %h exp %h", v, e); end
      e = exp_q.pop_front(); n_run++;
      if (PortOut !== e) begin n_fail++; $display("FAIL rw_write got %h exp %h", PortOut, e); end
   endtask

   task automatic test_decode;
      for (int o = 0; o < 32; o++) begin
         Address = BASE + 32'(o);
         exp_q.push_back(32'((o % 4 == 0) && o <= 32'h14));
         #1;
         e = exp_q.pop_front(); n_run++;
         if (32'(Hit) !== e) begin n_fail++; $display("FAIL decode_hit ofs %0h got %h exp %h", o, Hit, e); end
      end
      Address = BASE + 32'h20;
      exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); n_run++;
      if (32'(Hit) !== e) begin n_fail++; $display("FAIL decode_base got %h exp %h", Hit, e); end
   endtask

   task automatic test_portin;
      PortIn = 8'h81;
      tick(1);
      rd(BASE + 4, v, h);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL portin_1cyc got %h exp %h", v, e); end
      tick(1);
      rd(BASE + 4, v, h);
      exp_q.push_back(32'h81);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL portin_2cyc got %h exp %h", v, e); end
      tick(1);
      rd(BASE + 8, v, h);
      exp_q.push_back(32'h81);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL edge_set got %h exp %h", v, e); end
      wr(BASE + 8, 32'h01);
      rd(BASE + 8, v, h);
      exp_q.push_back(32'h80);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL edge_w1c got %h exp %h", v, e); end
      PortIn = 8'h80;
      tick(3);
      PortIn = 8'h81;
      tick(2);
      wr(BASE + 8, 32'h81);
      rd(BASE + 8, v, h);
      exp_q.push_back(32'h01);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL edge_collide got %h exp %h", v, e); end
   endtask

   task automatic test_oneshot;
      wr(BASE + 32'h0C, 32'h8);
      wr(BASE + 32'h10, 32'd3);
      wr(BASE + 32'h14, 32'd0);
      wr(BASE + 32'h0C, 32'h5);
      for (int i = 0; i < 5; i++) exp_q.push_back(i < 4 ? 32'(i) : 32'd0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick(1);
         rd(BASE + 32'h14, v, h);
         e = exp_q.pop_front(); n_run++;
         if (v !== e) begin n_fail++; $display("FAIL oneshot_cnt step %0d got %h exp %h", i, v, e); end
      end
      exp_q.push_back(32'h1);
      e = exp_q.pop_front(); n_run++;
      if (32'(TimerIRQ) !== e) begin n_fail++; $display("FAIL oneshot_irq got %h exp %h", TimerIRQ, e); end
      tick(2);
      rd(BASE + 32'h0C, v, h);
      exp_q.push_back(32'hC);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL oneshot_ctrl got %h exp %h", v, e); end
      rd(BASE + 32'h14, v, h);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL oneshot_hold got %h exp %h", v, e); end
      wr(BASE + 32'h0C, 32'h8);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_run++;
      if (32'(TimerIRQ) !== e) begin n_fail++; $display("FAIL oneshot_irqclr got %h exp %h", TimerIRQ, e); end
   endtask

   task automatic test_auto;
      wr(BASE + 32'h10, 32'd1);
      wr(BASE + 32'h14, 32'd0);
      wr(BASE + 32'h0C, 32'h3);
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(i % 2));
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick(1);
         rd(BASE + 32'h14, v, h);
         e = exp_q.pop_front(); n_run++;
         if (v !== e) begin n_fail++; $display("FAIL auto_cnt step %0d got %h exp %h", i, v, e); end
      end
      rd(BASE + 32'h0C, v, h);
      exp_q.push_back(32'hB);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL auto_ctrl got %h exp %h", v, e); end
      wr(BASE + 32'h0C, 32'hB);
      rd(BASE + 32'h0C, v, h);
      exp_q.push_back(32'hB);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL auto_collide got %h exp %h", v, e); end
      wr(BASE + 32'h0C, 32'hB);
      rd(BASE + 32'h0C, v, h);
      exp_q.push_back(32'h3);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL auto_w1c got %h exp %h", v, e); end
      wr(BASE + 32'h0C, 32'h8);
      wr(BASE + 32'h0C, 32'h8);
   endtask

   task automatic test_wrap;
      wr(BASE + 32'h10, 32'h10);
      wr(BASE + 32'h14, 32'hFFFF_FFFF);
      wr(BASE + 32'h0C, 32'h1);
      exp_q.push_back(32'hFFFF_FFFF);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick(1);
         rd(BASE + 32'h14, v, h);
         e = exp_q.pop_front(); n_run++;
         if (v !== e) begin n_fail++; $display("FAIL wrap_cnt step %0d got %h exp %h", i, v, e); end
      end
      wr(BASE + 32'h14, 32'd7);
      rd(BASE + 32'h14, v, h);
      exp_q.push_back(32'd7);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL override_cnt got %h exp %h", v, e); end
      tick(1);
      rd(BASE + 32'h14, v, h);
      exp_q.push_back(32'd8);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL override_next got %h exp %h", v, e); end
      wr(BASE + 32'h0C, 32'h0);
   endtask

   task automatic test_reset_mid;
      wr(BASE + 32'h10, 32'd0);
      wr(BASE + 32'h0C, 32'h5);
      wr(BASE + 32'h14, 32'd5);
      wr(BASE, 32'hAA);
      #2;
      reset = 1;
      #1;
      MemRead = 1; Address = BASE + 32'h14;
      #1;
      v = ReadData;
      MemRead = 0;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_run++;
      if (PortOut !== e) begin n_fail++; $display("FAIL midreset_portout got %h exp %h", PortOut, e); end
      e = exp_q.pop_front(); n_run++;
      if (32'(TimerIRQ) !== e) begin n_fail++; $display("FAIL midreset_irq got %h exp %h", TimerIRQ, e); end
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL midreset_cnt got %h exp %h", v, e); end
      @(negedge clk);
      reset = 0;
      tick(1);
      rd(BASE, v, h);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); n_run++;
      if (v !== e) begin n_fail++; $display("FAIL postreset_read got %h exp %h", v, e); end
   endtask

   initial begin
      test_reset;
      test_port;
      test_decode;
      test_portin;
      test_oneshot;
      test_auto;
      test_wrap;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/mmio_port_unit.md
Name: mmio_port_unit

Overview:
- Memory-mapped I/O stage directly downstream of the single-cycle MIPS datapath.
- Consumes the ALU result as a byte address and rs2 data as store data.
- Owns the processor's PortOut register and the synchronised PortIn capture.
- Adds rising-edge flags on PortIn and a compare/reload timer with an interrupt line.
- Reads are combinational so a lw completes in its own cycle; writes commit on the clock edge.

Parameters:
- BASE_ADDR, 32'h1001_0100: byte base of the register window; must be 32-byte aligned.
- IN_WIDTH, 8: PortIn width.
- SYNC_STAGES, 2: synchroniser depth for PortIn; minimum 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- MemWrite  input  1  store strobe from control.
- MemRead  input  1  load strobe from control.
- Address  input  32  byte address, taken from ALUResult.
- WriteData  input  32  store data, taken from ReadData2.
- ReadData  output  32  load data; combinational.
- Hit  output  1  access decodes to a valid register of this unit; combinational.
- PortIn  input  IN_WIDTH  asynchronous external inputs.
- PortOut  output  32  registered output port.
- TimerIRQ  output  1  timer interrupt request, level.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While it is asserted:
  - PortOut, edge flags, all timer registers and synchroniser flops are 0.
  - TimerIRQ is 0.
- Decode: Hit=1 only when all of the following hold:
  - Address[31:5]==BASE_ADDR[31:5]
  - Address[1:0]==0
  - offset=Address[4:0] is one of 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14
  - Misaligned or unmapped offsets give Hit=0, no write, and ReadData=0.
- Register map:
  - 0x00 PORT_OUT RW.
  - 0x04 PORT_IN RO: zero-extended synchronised value.
  - 0x08 EDGE RW1C: bits [IN_WIDTH-1:0].
  - 0x0C CTRL: bit0 EN, bit1 AUTO, bit2 IRQEN, bit3 STATUS (RW1C); other bits read 0.
  - 0x10 CMP RW.
  - 0x14 CNT RW.
- Reads: ReadData = selected register when MemRead & Hit, else 0; no latency.
- Writes: take effect at the rising edge when MemWrite & Hit. Writes to RO offsets are ignored.
- MemRead & MemWrite together: the read returns the pre-write value.
- PortIn path:
  - SYNC_STAGES flop chain, then a prev flop.
  - PORT_IN = last sync stage; changes appear at PORT_IN 2 cycles after PortIn changes (SYNC_STAGES=2).
  - EDGE[i] sets on sync[i]=1 & prev[i]=0.
- EDGE clear: writing 1 clears a bit; writing 0 has no effect. A new edge in the same cycle as a clear wins (bit stays 1).
- Timer, each cycle with EN=1:
  - CNT==CMP: CNT<=0, STATUS<=1, and EN<=AUTO.
  - Otherwise CNT<=CNT+1, wrapping 32'hFFFF_FFFF→0.
  - EN=0: CNT holds.
  - CMP=0 with EN=1: match every cycle; STATUS is held at 1.
- Timer write priority:
  - A CPU write to CNT in a cycle overrides increment/match for CNT.
  - A CTRL write updates EN/AUTO/IRQEN from data, and STATUS clears if data bit3=1.
  - If a match occurs in the same cycle, STATUS set wins over clear, and EN follows the written value.
- Interrupt: TimerIRQ = STATUS & IRQEN, driven combinationally from registers.
- Reset mid-count: immediate clear, with no pending match retained.

Decomposition:
- Shared package mmio_pkg holds:
  - register offset constants (OFS_PORT_OUT…OFS_CNT)
  - CTRL bit index constants (CTRL_EN, CTRL_AUTO, CTRL_IRQEN, CTRL_STATUS)
  - the default BASE_ADDR
- Sub-module port_in_sync: synchroniser chain plus prev flop. Outputs sync_value and rise_pulse; parameters IN_WIDTH and SYNC_STAGES.
- Decode, register file and timer stay in the top module.

Test Plan:
- Reset: assert reset mid-operation with CNT=5, PortOut=0xAA → all outputs 0 immediately and without a clock edge; after deassert, a read of 0x1001_0100 gives 0.
- Port write/read: sw 0x0000_00A5 to 0x1001_0100 → PortOut=0xA5 after the edge. lw from the same address gives 0xA5 in the same cycle with Hit=1. sw to 0x1001_0102 (misaligned) → Hit=0 and PortOut unchanged.
- PortIn sync and edge: PortIn 0x00→0x81 → PORT_IN reads 0x81 exactly 2 cycles later and EDGE=0x81. Write 0x01 to 0x08 → EDGE=0x80. A new bit-0 rise coinciding with the clear → EDGE bit0 stays 1.
- Timer one-shot: CMP=3, CTRL=0x5 (EN, IRQEN) → CNT 0,1,2,3 then 0, STATUS=1 and TimerIRQ=1 on the 5th edge; EN reads 0 afterward and CNT stays 0. Write 0x8 to CTRL → TimerIRQ=0.
- Timer auto-reload and collision: CMP=1, CTRL=0x3 → STATUS set every 2 cycles and EN stays 1. A W1C of STATUS on a match cycle → STATUS remains 1.
- Wrap/override: write CNT=0xFFFF_FFFF with CMP=0x10 and EN=1 → next CNT=0. Write CNT=7 while counting → CNT=7 that edge, with no increment applied.
